// File: rtl/seg_pkg.sv
// Shared glyph type, hex glyph table and segment-off constant for the scan controller.
package seg_pkg;

   // Segment glyph in active-high form, bit order {g,f,e,d,c,b,a}
   typedef logic [6:0] glyph_t;

   localparam glyph_t SEG_OFF = 7'b0000000;

   localparam glyph_t GLYPH_TABLE [16] = '{
      7'b0111111,  // 0
      7'b0000110,  // 1
      7'b1011011,  // 2
      7'b1001111,  // 3
      7'b1100110,  // 4
      7'b1101101,  // 5
      7'b1111101,  // 6
      7'b0000111,  // 7
      7'b1111111,  // 8
      7'b1101111,  // 9
      7'b1110111,  // A
      7'b1111100,  // b
      7'b0111001,  // C
      7'b1011110,  // d
      7'b1111001,  // E
      7'b1110001   // F
   };

   // Convert an active-high glyph to the pin polarity of the display
   function automatic glyph_t seg_polarity(input glyph_t i_glyph, input bit i_active_low);
      return i_active_low ? ~i_glyph : i_glyph;
   endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to seven-segment glyph decoder (active-high output).
module seg_hex_decoder
   import seg_pkg::*;
(
   input  logic [3:0] i_nibble,
   output glyph_t     o_glyph
);

   assign o_glyph = GLYPH_TABLE[i_nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous double-buffered loads,
// per-digit blanking, decimal points and leading-zero suppression.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned DIGITS         = 4,
   parameter int unsigned DIV_COUNT      = 100000,
   parameter int unsigned GAP_CYCLES     = 2,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  i_load,
   input  logic [4*DIGITS-1:0]   i_data,
   input  logic [DIGITS-1:0]     i_blank,
   input  logic [DIGITS-1:0]     i_dp,
   input  logic                  i_lzs,
   output logic [DIGITS-1:0]     digits,
   output logic [6:0]            lcd,
   output logic                  o_dp,
   output logic                  o_frame
);

   localparam int unsigned PW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV_COUNT - 1);
   localparam logic [PW-1:0] GAP_LEN    = PW'(GAP_CYCLES);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
   localparam glyph_t        LCD_OFF    = seg_polarity(SEG_OFF, SEG_ACTIVE_LOW);

   // Scan state
   logic [PW-1:0]       r_presc;
   logic [IW-1:0]       r_idx;

   // Pending (written by i_load) and active (displayed) buffers
   logic                r_pend_valid;
   logic [4*DIGITS-1:0] r_pend_data;
   logic [DIGITS-1:0]   r_pend_blank;
   logic [DIGITS-1:0]   r_pend_dp;
   logic                r_pend_lzs;
   logic [4*DIGITS-1:0] r_act_data;
   logic [DIGITS-1:0]   r_act_blank;
   logic [DIGITS-1:0]   r_act_dp;
   logic                r_act_lzs;

   // Registered outputs
   logic [DIGITS-1:0]   r_digits;
   glyph_t              r_lcd;
   logic                r_dp;
   logic                r_frame;

   logic                w_tick;
   logic                w_wrap;
   logic [PW-1:0]       w_presc_d;
   logic [IW-1:0]       w_idx_d;
   logic [4*DIGITS-1:0] w_act_data_d;
   logic [DIGITS-1:0]   w_act_blank_d;
   logic [DIGITS-1:0]   w_act_dp_d;
   logic                w_act_lzs_d;
   logic [DIGITS-1:0]   w_lz_blank;
   logic                w_zero_run;
   logic [3:0]          w_nibble;
   glyph_t              w_glyph;
   logic                w_gap;
   logic                w_blank;
   glyph_t              w_seg;
   logic                w_dp_on;
   logic [DIGITS-1:0]   w_digits_d;

   // Prescaler / digit-index next state; a wrap is the tick that leaves the last digit
   always_comb begin
      w_tick    = (r_presc == PRESC_LAST);
      w_wrap    = w_tick && (r_idx == IDX_LAST);
      w_presc_d = w_tick ? '0 : r_presc + 1'b1;
      w_idx_d   = r_idx;
      if (w_tick) begin
         w_idx_d = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
   end

   // Active buffer only changes on a wrap; a load on the wrap edge bypasses the pending buffer
   always_comb begin
      w_act_data_d  = r_act_data;
      w_act_blank_d = r_act_blank;
      w_act_dp_d    = r_act_dp;
      w_act_lzs_d   = r_act_lzs;
      if (w_wrap) begin
         if (i_load) begin
            w_act_data_d  = i_data;
            w_act_blank_d = i_blank;
            w_act_dp_d    = i_dp;
            w_act_lzs_d   = i_lzs;
         end else if (r_pend_valid) begin
            w_act_data_d  = r_pend_data;
            w_act_blank_d = r_pend_blank;
            w_act_dp_d    = r_pend_dp;
            w_act_lzs_d   = r_pend_lzs;
         end
      end
   end

   // Leading-zero mask: digit k>0 is suppressible when it and every digit above it are zero
   always_comb begin
      w_zero_run = 1'b1;
      w_lz_blank = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         w_zero_run = w_zero_run & (w_act_data_d[4*k +: 4] == 4'h0);
         if (k > 0) begin
            w_lz_blank[k] = w_zero_run;
         end
      end
   end

   // Outputs are computed from next state so they land together with the new slot
   assign w_nibble = w_act_data_d[{w_idx_d, 2'b00} +: 4];

   seg_hex_decoder u_dec (
      .i_nibble (w_nibble),
      .o_glyph  (w_glyph)
   );

   // Next output values: gap blanks everything, blank/lzs only blanks the segments
   always_comb begin
      w_gap      = (w_presc_d < GAP_LEN);
      w_blank    = w_act_blank_d[w_idx_d] | (w_act_lzs_d & w_lz_blank[w_idx_d]);
      w_seg      = (w_gap || w_blank) ? SEG_OFF : w_glyph;
      w_dp_on    = !w_gap && w_act_dp_d[w_idx_d];
      w_digits_d = '1;
      if (!w_gap) begin
         w_digits_d[w_idx_d] = 1'b0;
      end
   end

   // Scan counters
   always_ff @(posedge clock) begin
      if (reset) begin
         r_presc <= '0;
         r_idx   <= '0;
      end else begin
         r_presc <= w_presc_d;
         r_idx   <= w_idx_d;
      end
   end

   // Pending buffer: last load wins; consumed (valid cleared) on every wrap
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pend_valid <= 1'b0;
         r_pend_data  <= '0;
         r_pend_blank <= '1;
         r_pend_dp    <= '0;
         r_pend_lzs   <= 1'b0;
      end else begin
         if (i_load) begin
            r_pend_data  <= i_data;
            r_pend_blank <= i_blank;
            r_pend_dp    <= i_dp;
            r_pend_lzs   <= i_lzs;
         end
         if (w_wrap) begin
            r_pend_valid <= 1'b0;
         end else if (i_load) begin
            r_pend_valid <= 1'b1;
         end
      end
   end

   // Active (displayed) buffer
   always_ff @(posedge clock) begin
      if (reset) begin
         r_act_data  <= '0;
         r_act_blank <= '1;
         r_act_dp    <= '0;
         r_act_lzs   <= 1'b0;
      end else begin
         r_act_data  <= w_act_data_d;
         r_act_blank <= w_act_blank_d;
         r_act_dp    <= w_act_dp_d;
         r_act_lzs   <= w_act_lzs_d;
      end
   end

   // Registered display outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         r_digits <= '1;
         r_lcd    <= LCD_OFF;
         r_dp     <= SEG_ACTIVE_LOW;
         r_frame  <= 1'b0;
      end else begin
         r_digits <= w_digits_d;
         r_lcd    <= seg_polarity(w_seg, SEG_ACTIVE_LOW);
         r_dp     <= w_dp_on ^ SEG_ACTIVE_LOW;
         r_frame  <= w_wrap;
      end
   end

   assign digits  = r_digits;
   assign lcd     = r_lcd;
   assign o_dp    = r_dp;
   assign o_frame = r_frame;

endmodule
